react_test_ctrl: RTL
====================

Name: react_test_ctrl

Overview:
Session controller for the body-reaction detector. On a start press it runs ROUNDS trials. Each trial waits a pseudo-random foreperiod, then asserts random_finish to the reaction-time counter and collects t_react or a timeout. It handles false starts and publishes the last, best and average reaction times to the display logic.

Parameters:
ROUNDS, 4, trials per session; power of two, 1..16
MIN_DELAY, 1000, minimum foreperiod in clock cycles (1 cycle = 1 ms)
RAND_BITS, 12, width of the random foreperiod extension (0..2^RAND_BITS-1 cycles)
TIMEOUT_MS, 10000, value recorded for a trial that ends on react_exceed
HOLD_CYCLES, 2000, display hold time in RESULT and FALSE_START

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  start button, synchronised level
react  in  1  reaction button, synchronised level
t_react  in  32  reaction time from the counter; 0 while not finished
react_exceed  in  1  timeout flag from the counter
random_finish  out  1  enables the counter; high only in MEASURE
go_led  out  1  stimulus indicator; equals random_finish
state  out  3  IDLE=0, DELAY=1, MEASURE=2, RESULT=3, FALSE_START=4, DONE=5
round_idx  out  4  completed valid trials in this session
last_time  out  32  most recent valid trial time
best_time  out  32  minimum valid trial time; 32'hFFFFFFFF when none
avg_time  out  32  sum of trial times >> log2(ROUNDS); valid in DONE
done  out  1  high in DONE
false_start  out  1  high in FALSE_START

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except best_time=32'hFFFFFFFF; LFSR=16'hACE1; sum=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state.
- start_rise = start & ~start_q, with start_q registered. start is used only through start_rise.
- IDLE: on start_rise, clear round_idx, sum, last_time and avg_time; set best_time=all ones; go to DELAY.
- Entering DELAY: load delay_cnt = MIN_DELAY + LFSR[RAND_BITS-1:0]. The load uses the LFSR value in the transition cycle.
- DELAY: decrement delay_cnt every cycle.
  - If react=1 in any DELAY cycle, including the cycle where delay_cnt reaches 0, go to FALSE_START. react takes priority over expiry.
  - Otherwise, when delay_cnt==0, go to MEASURE.
- MEASURE: random_finish=1 and go_led=1. The counter needs 1 cycle after random_finish rises. t_react is 0 on entry.
  - If t_react!=0, latch last_time=t_react.
  - Else if react_exceed=1, latch last_time=TIMEOUT_MS.
  - If both occur in the same cycle, t_react wins.
  - On either event: sum+=value; best_time=min(best_time,value); round_idx+=1; go to RESULT.
  - start_rise is ignored.
- RESULT: random_finish drops the same cycle the state changes, which clears the counter. Hold HOLD_CYCLES cycles.
  - If round_idx==ROUNDS, compute avg_time = sum >> log2(ROUNDS) and go to DONE.
  - Otherwise go to DELAY with a new foreperiod.
- FALSE_START: false_start=1. Hold HOLD_CYCLES cycles, then go to DELAY. The trial is repeated; round_idx, sum and best_time are unchanged.
- DONE: done=1; statistics held. start_rise behaves as in IDLE, starting a new session.
- Widths:
  - sum is 32+log2(ROUNDS) bits and never wraps.
  - avg_time truncates toward zero.
  - delay_cnt is wide enough for MIN_DELAY + 2^RAND_BITS - 1.
  - The hold counter is shared by RESULT and FALSE_START and reloads on entry.
- Reset mid-session returns to IDLE immediately; the counter sees random_finish=0.

Decomposition:
- Shared package react_pkg: state enum, LFSR seed and tap mask, TIMEOUT_MS default, 1 ms/cycle constant.
- One natural sub-module: react_lfsr16 (free-running LFSR; ports clock, reset, value[15:0]).
- Statistics (sum, best, average) stay inline.

Test Plan:
- Bench parameters: MIN_DELAY=4, RAND_BITS=2, HOLD_CYCLES=3, ROUNDS=4. t_react and react_exceed come from a behavioural counter model.
- Happy path: start pulse; counter reports 120, 80, 200, 40 -> last_time tracks each value; best_time=40; round_idx=4; avg_time=110; done=1.
- False start: react=1 in DELAY cycle 2 of trial 2 -> FALSE_START for 3 cycles, then DELAY; round_idx stays 1; the session still completes 4 valid trials.
- Timeout: react_exceed with t_react=0 in trial 3 -> last_time=10000; avg includes 10000; best_time unaffected unless smaller.
- Simultaneous events:
  - react at the delay expiry cycle -> FALSE_START.
  - t_react!=0 and react_exceed in the same cycle -> last_time=t_react.
- Reset during MEASURE -> next cycle state=0, random_finish=0, best_time=FFFFFFFF, round_idx=0.
- DONE restart: start_rise in DONE -> stats cleared, state=DELAY. start held high shows no second rise. start_rise during MEASURE is ignored.

Source files
------------

// File: rtl/react_pkg.sv
// rtl/react_pkg.sv - shared types and constants for the reaction test controller
package react_pkg;

    // Session states; encodings are visible on the state output
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DELAY       = 3'd1,
        ST_MEASURE     = 3'd2,
        ST_RESULT      = 3'd3,
        ST_FALSE_START = 3'd4,
        ST_DONE        = 3'd5
    } react_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Taps 16,14,13,11 of a right-shifting Fibonacci register sit at bit positions 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Time recorded for a trial that ends without a reaction
    localparam int TIMEOUT_MS_DEFAULT = 10000;

    // The controller clock runs at 1 kHz, so one cycle is one millisecond
    localparam int CYCLES_PER_MS = 1;

endpackage

// File: rtl/react_lfsr16.sv
// rtl/react_lfsr16.sv - free-running 16-bit Fibonacci LFSR for foreperiod randomisation
module react_lfsr16
    import react_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);
    assign value      = r_lfsr;

    // Shift right every cycle, feeding the tap parity back into the MSB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_feedback, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/react_test_ctrl.sv
// rtl/react_test_ctrl.sv - reaction test session controller with trial statistics
module react_test_ctrl
    import react_pkg::*;
#(
    parameter int ROUNDS      = 4,
    parameter int MIN_DELAY   = 1000 * CYCLES_PER_MS,
    parameter int RAND_BITS   = 12,
    parameter int TIMEOUT_MS  = TIMEOUT_MS_DEFAULT,
    parameter int HOLD_CYCLES = 2000 * CYCLES_PER_MS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        react,
    input  logic [31:0] t_react,
    input  logic        react_exceed,
    output logic        random_finish,
    output logic        go_led,
    output logic [2:0]  state,
    output logic [3:0]  round_idx,
    output logic [31:0] last_time,
    output logic [31:0] best_time,
    output logic [31:0] avg_time,
    output logic        done,
    output logic        false_start
);

    localparam int LOG2_R = $clog2(ROUNDS);
    localparam int SUM_W  = 32 + LOG2_R;
    localparam int RND_W  = $clog2(ROUNDS + 1);
    localparam int DLY_W  = $clog2(MIN_DELAY + (1 << RAND_BITS));
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    react_state_e      r_state;
    react_state_e      w_next;
    logic              r_start_q;
    logic [DLY_W-1:0]  r_delay_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [RND_W-1:0]  r_round_idx;
    logic [SUM_W-1:0]  r_sum;
    logic [31:0]       r_last;
    logic [31:0]       r_best;
    logic [31:0]       r_avg;

    logic [15:0]       w_lfsr;
    logic              w_unused_lfsr;
    logic              w_start_rise;
    logic              w_meas_hit;
    logic [31:0]       w_meas_val;
    logic              w_last_round;
    logic              w_hold_done;
    logic [DLY_W-1:0]  w_delay_seed;

    react_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (w_lfsr)
    );

    // Only the low RAND_BITS of the LFSR shape the foreperiod
    assign w_unused_lfsr = ^w_lfsr;

    assign w_start_rise = start & ~r_start_q;
    assign w_meas_hit   = (t_react != 32'd0) | react_exceed;
    assign w_meas_val   = (t_react != 32'd0) ? t_react : 32'(TIMEOUT_MS);
    assign w_last_round = (r_round_idx == RND_W'(ROUNDS));
    assign w_hold_done  = (r_hold_cnt == '0);
    assign w_delay_seed = DLY_W'(MIN_DELAY) + DLY_W'(w_lfsr[RAND_BITS-1:0]);

    assign random_finish = (r_state == ST_MEASURE);
    assign go_led        = random_finish;
    assign state         = r_state;
    assign round_idx     = 4'(r_round_idx);
    assign last_time     = r_last;
    assign best_time     = r_best;
    assign avg_time      = r_avg;
    assign done          = (r_state == ST_DONE);
    assign false_start   = (r_state == ST_FALSE_START);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; react beats foreperiod expiry, t_react beats timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_rise) w_next = ST_DELAY;
            end
            ST_DELAY: begin
                if (react)                     w_next = ST_FALSE_START;
                else if (r_delay_cnt == '0)    w_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_meas_hit) w_next = ST_RESULT;
            end
            ST_RESULT: begin
                if (w_hold_done) w_next = w_last_round ? ST_DONE : ST_DELAY;
            end
            ST_FALSE_START: begin
                if (w_hold_done) w_next = ST_DELAY;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Foreperiod and display-hold counters, reloaded on entry to their states
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_q   <= 1'b0;
            r_delay_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_start_q <= start;

            if (r_state == ST_DELAY) begin
                r_delay_cnt <= r_delay_cnt - DLY_W'(1);
            end
            if ((w_next == ST_DELAY) && (r_state != ST_DELAY)) begin
                r_delay_cnt <= w_delay_seed;
            end

            if (!w_hold_done) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
            if (((w_next == ST_RESULT) || (w_next == ST_FALSE_START)) && (w_next != r_state)) begin
                r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            end
        end
    end

    // Session statistics: cleared on a new session, updated once per valid trial
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_round_idx <= '0;
            r_sum       <= '0;
            r_last      <= '0;
            r_best      <= '1;
            r_avg       <= '0;
        end else begin
            if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_start_rise) begin
                r_round_idx <= '0;
                r_sum       <= '0;
                r_last      <= '0;
                r_best      <= '1;
                r_avg       <= '0;
            end
            if ((r_state == ST_MEASURE) && w_meas_hit) begin
                r_last      <= w_meas_val;
                r_sum       <= r_sum + SUM_W'(w_meas_val);
                r_round_idx <= r_round_idx + RND_W'(1);
                if (w_meas_val < r_best) r_best <= w_meas_val;
            end
            if ((r_state == ST_RESULT) && w_hold_done && w_last_round) begin
                r_avg <= 32'(r_sum >> LOG2_R);
            end
        end
    end

endmodule
